// File: rtl/linear_mac_seq.sv
// Time-multiplexed 11x11 fixed-point linear layer (y = W*x + b) with one MAC.
// Streams x in, reads weights/bias from a synchronous-read memory, streams y out.
module linear_mac_seq #(
  parameter int DW   = 12,
  parameter int N    = 11,
  parameter int FRAC = 6,
  parameter int ACCW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          rd_en,
  output logic [7:0]    rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(1 << (DW - 1)));

  // state   | meaning
  // S_LOAD  | accepting x[0..N-1] from the input stream
  // S_MAC   | k=0..N: issue weight/bias reads, accumulate previous weight * x[k-1]
  // S_DRAIN | add bias, round down, saturate, register the output beat
  // S_OUT   | hold the beat until the downstream handshake
  typedef enum logic [1:0] {S_LOAD, S_MAC, S_DRAIN, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          row_q, row_d;
  logic [CW-1:0]          k_q, k_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0]   x_q [N];
  logic signed [DW-1:0]   x_d [N];
  logic [7:0]             rd_addr_q;
  logic                   out_valid_q, out_valid_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;

  logic [CW-1:0]          k_prev;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] bias_sh;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] shifted;
  logic [DW-1:0]          sat_val;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    k_d         = k_q;
    acc_d       = acc_q;
    x_d         = x_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    rd_en       = 1'b0;
    rd_addr     = rd_addr_q;
    in_ready    = (state_q == S_LOAD) && !rst;

    // x index is only consumed for k>=1; clamp keeps the read in range at k=0
    k_prev  = (k_q == '0) ? '0 : k_q - CW'(1);
    prod    = signed'(rd_data) * x_q[k_prev];
    bias_sh = ACCW'(signed'(rd_data)) <<< FRAC;
    sum     = acc_q + bias_sh;
    shifted = sum >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DW-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DW-1:0];
    else                        sat_val = shifted[DW-1:0];

    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          x_d[cnt_q] = in_data;
          busy_d     = 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            cnt_d   = '0;
            row_d   = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_MAC: begin
        rd_en = 1'b1;
        if (k_q == CW'(N)) rd_addr = 8'(N * N) + 8'(row_q);
        else               rd_addr = 8'(row_q) * 8'(N) + 8'(k_q);
        if (k_q != '0) acc_d = acc_q + ACCW'(prod);
        if (k_q == CW'(N)) state_d = S_DRAIN;
        else               k_d     = k_q + CW'(1);
      end
      S_DRAIN: begin
        acc_d       = sum;
        out_data_d  = sat_val;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == CW'(N - 1));
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (row_q == CW'(N - 1)) begin
            busy_d  = 1'b0;
            state_d = S_LOAD;
          end else begin
            row_d   = row_q + CW'(1);
            k_d     = '0;
            acc_d   = '0;
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      cnt_q       <= '0;
      row_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      rd_addr_q   <= rd_addr;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_linear_mac_seq.sv
// Directed + randomized bench for linear_mac_seq against a plain-arithmetic
// reference of y = sat(floor((W*x + b*2^FRAC) / 2^FRAC)).
module tb_linear_mac_seq;
  localparam int DW = 12, N = 11, FRAC = 6, ACCW = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          rd_en;
  logic [7:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  linear_mac_seq #(.DW(DW), .N(N), .FRAC(FRAC), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  logic signed [DW-1:0] mem [N*N+N];
  logic signed [DW-1:0] xv [N];
  logic [7:0]           addr_log [$];
  int checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(negedge clk) if (rd_en) addr_log.push_back(rd_addr);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_y(input int r);
    longint a = 0;
    for (int c = 0; c < N; c++) a += longint'(mem[r*N+c]) * longint'(xv[c]);
    a += longint'(mem[N*N+r]) * 64;
    a = a >>> FRAC;
    if (a > 2047) a = 2047;
    else if (a < -2048) a = -2048;
    return a[DW-1:0];
  endfunction

  task automatic feed(input int start, input int gap_pct, output int base);
    for (int i = start; i < N; i++) begin
      for (int g = 0; g < 4 && int'($urandom_range(99)) < gap_pct; g++) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = xv[i];
      check("in_ready_load", in_ready, 1);
      tick();
      if (i == 0) check("busy_rise", busy, 1);
    end
    in_valid = 1'b0;
    base = cyc;
  endtask

  task automatic collect(input int bp_row, input int bp_len, input bit hold_next,
                         input int abort_row, input int base);
    logic [DW-1:0] exp_y [N];
    logic [DW-1:0] held_d;
    logic          held_l;
    int beat = 0, stall = 0, t_prev = 0, guard = 0;
    bit seen = 0;
    for (int r = 0; r < N; r++) exp_y[r] = ref_y(r);
    out_ready = 1'b1;
    while (beat < N && guard < 600) begin
      if (abort_row >= 0 && beat == abort_row) return;
      if (hold_next) check("in_ready_blocked", in_ready, 0);
      if (out_valid) begin
        if (!seen) begin
          seen = 1;
          if (beat == 0) check("first_latency", cyc - base, 13);
          else check("row_period", cyc - t_prev, (beat == bp_row + 1) ? 14 + bp_len : 14);
          t_prev = cyc;
          check($sformatf("y[%0d]", beat), out_data, exp_y[beat]);
          check($sformatf("last[%0d]", beat), out_last, beat == N - 1);
          held_d = out_data;
          held_l = out_last;
          if (beat == bp_row) stall = bp_len;
        end else begin
          check("stall_data", out_data, held_d);
          check("stall_last", out_last, held_l);
          check("stall_rd_en", rd_en, 0);
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = 1'b1;
          beat++;
          seen = 0;
        end
      end
      tick();
      guard++;
    end
    check("collect_beats", beat, N);
    out_ready = 1'b1;
    check("busy_fall", busy, 0);
    check("valid_after_last", out_valid, 0);
  endtask

  task automatic set_mem_rand;
    for (int i = 0; i < N*N+N; i++) mem[i] = DW'($urandom);
  endtask

  task automatic set_x_rand;
    for (int i = 0; i < N; i++) xv[i] = DW'($urandom);
  endtask

  initial begin
    int base, extra;
    logic signed [DW-1:0] nx0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int i = 0; i < N*N+N; i++) mem[i] = '0;
    #1;
    tick();
    check("in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);

    // identity
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mem[r*N+c] = (r == c) ? 12'sd64 : 12'sd0;
    for (int i = 0; i < N; i++) xv[i] = DW'(64 * (i + 1));
    feed(0, 0, base);
    collect(-1, 0, 0, -1, base);
    extra = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (out_valid) extra++; end
    check("no_extra_beats", extra, 0);

    // bias only, with address trace
    for (int i = 0; i < N*N; i++) mem[i] = '0;
    for (int r = 0; r < N; r++) mem[N*N+r] = DW'(64 * r - 320);
    set_x_rand();
    addr_log.delete();
    feed(0, 0, base);
    collect(-1, 0, 0, -1, base);
    check("addr_count", addr_log.size(), N * (N + 1));
    if (addr_log.size() == N * (N + 1)) begin
      for (int c = 0; c <= N; c++) begin
        check("addr_row0", addr_log[c], (c < N) ? c : 121);
        check("addr_row10", addr_log[(N-1)*(N+1)+c], (c < N) ? 110 + c : 131);
      end
    end

    // positive saturation
    for (int i = 0; i < N*N+N; i++) mem[i] = (i < N*N) ? 12'sd2047 : 12'sd0;
    for (int i = 0; i < N; i++) xv[i] = 12'sd2047;
    feed(0, 0, base);
    collect(-1, 0, 0, -1, base);

    // negative saturation
    for (int i = 0; i < N*N; i++) mem[i] = -12'sd2048;
    feed(0, 0, base);
    collect(-1, 0, 0, -1, base);

    // floor of a tiny negative product
    for (int i = 0; i < N*N+N; i++) mem[i] = '0;
    mem[0] = -12'sd1;
    for (int i = 0; i < N; i++) xv[i] = '0;
    xv[0] = 12'sd1;
    feed(0, 0, base);
    collect(-1, 0, 0, -1, base);

    // output backpressure at row 3
    set_mem_rand();
    set_x_rand();
    feed(0, 0, base);
    collect(3, 5, 0, -1, base);

    // input bubbles, then a 12th word held against in_ready
    set_mem_rand();
    set_x_rand();
    nx0 = DW'($urandom);
    feed(0, 40, base);
    in_valid = 1'b1;
    in_data  = nx0;
    collect(-1, 0, 1, -1, base);
    check("overlap_ready_after_last", in_ready, 1);
    tick();
    check("overlap_busy", busy, 1);
    in_valid = 1'b0;
    xv[0] = nx0;
    for (int i = 1; i < N; i++) xv[i] = DW'($urandom);
    feed(1, 30, base);
    collect(-1, 0, 0, -1, base);

    // reset during MAC of row 5
    set_mem_rand();
    set_x_rand();
    feed(0, 0, base);
    collect(-1, 0, 0, 5, base);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (out_valid) extra++; end
    check("midrst_no_stale", extra, 0);
    set_x_rand();
    feed(0, 20, base);
    collect(-1, 0, 0, -1, base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/linear_mac_seq.md
# linear_mac_seq

Sequencer for one 11x11 fixed-point linear layer (y = W·x + b) that time-multiplexes a single multiply-accumulate datapath. It accepts the input vector over a valid/ready stream and fetches weights and biases from a single synchronous-read parameter memory. It emits the 11 outputs one row at a time on a valid/ready output stream. It replaces the fully parallel linear datapath where area matters more than latency.

## Interface
- `DW`, default 12: word width; signed two's complement for inputs, weights, biases and outputs.
- `N`, default 11: vector length and matrix dimension.
- `FRAC`, default 6: fractional bits of every operand and of the result.
- `ACCW`, default 28: accumulator width (2·DW + 4).
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, 1: input element valid.
- `in_ready`, out, 1: block accepts an input element.
- `in_data`, in, DW: input element; x[0] first, x[N-1] last.
- `rd_en`, out, 1: parameter memory read strobe.
- `rd_addr`, out, 8: parameter address; weights at row·N+col (0..120), bias b[r] at N·N+r (121..131).
- `rd_data`, in, DW: parameter word, valid exactly 1 cycle after `rd_en`.
- `out_valid`, out, 1: output element valid.
- `out_ready`, in, 1: downstream accepts the output.
- `out_data`, out, DW: y[row], saturated.
- `out_last`, out, 1: high with the y[N-1] beat.
- `busy`, out, 1: high from the first input accept until the `out_last` handshake.

## Operation
- The FSM has four states: LOAD, MAC, DRAIN, OUT.
- **LOAD:**
  - `in_ready`=1.
  - Each `in_valid`&`in_ready` stores `in_data` into x[cnt] and increments cnt.
  - On the N-th accept: cnt←0, row←0, acc←0, go to MAC.
- **MAC:** lasts N+1 cycles, k=0..N.
  - For k<N: `rd_en`=1, `rd_addr`=row·N+k.
  - For k=N: `rd_addr`=N·N+row.
  - On each cycle with k≥1, acc += sext(rd_data)·sext(x[k-1]), where rd_data holds the weight issued at k-1.
  - After k=N, go to DRAIN.
- **DRAIN:** one cycle, `rd_en`=0.
  - rd_data is the bias; acc += sext(rd_data) << FRAC.
  - The next-state value r = (acc + (bias<<FRAC)) >>> FRAC, an arithmetic shift (floor).
  - r is saturated to [-2^(DW-1), 2^(DW-1)-1] and registered into `out_data`.
  - `out_valid`←1, `out_last`←(row==N-1), go to OUT.
- **OUT:**
  - Hold `out_data` and `out_last` until `out_valid`&`out_ready`.
  - On the handshake `out_valid`←0.
  - If row==N-1: go to LOAD and `busy`←0.
  - Otherwise: row++, acc←0, go to MAC.
- Products are 2·DW bits signed; the accumulator never wraps for any operands (ACCW is sufficient).
- `rd_en`=0 and `rd_addr` holds its last value outside MAC.

## Timing
- Reset values: state=LOAD, cnt=0, row=0, acc=0, `in_ready`=0 during the rst cycle then 1, `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- `busy` rises on the cycle after the first input accept.
- Latency:
  - The clock edge that accepts x[N-1] is cycle 0.
  - MAC runs cycles 1..12, DRAIN is cycle 13, `out_valid` is first high in cycle 14.
- Row period with `out_ready` held high is 14 cycles (12 MAC + 1 DRAIN + 1 OUT). A full vector takes 154 cycles after the last input.
- Backpressure: while `out_valid`&!`out_ready`, nothing advances, `rd_en`=0, and outputs stay stable.
- `in_ready`=0 in MAC/DRAIN/OUT, so no input of the next vector is accepted before the `out_last` handshake. The first new accept is possible in the cycle after it.
- `in_valid` bubbles in LOAD are allowed; cnt holds.
- Reset mid-operation: `rst` in any state discards x, acc and the pending output. `out_valid`=0 from the next cycle, and no stale beat is ever emitted.
- Parameter memory contents must be stable while `busy`=1.

## Test plan
- **Identity:** W=64·I (1.0), b=0, x[i]=64·(i+1) → y[i]=64·(i+1); exactly 11 beats; `out_last` only on the 11th; first `out_valid` at cycle 14.
- **Bias only:** W=0, b[r]=64·r-320 → y[r]=64·r-320; confirm `rd_addr` sequence 0..10,121 for row 0 and 110..120,131 for row 10.
- **Saturation and floor:**
  - All W=2047, x=2047 → every y=2047.
  - W=-2048, x=2047 → every y=-2048.
  - W[0][0]=-1, x[0]=1, others 0 → y[0]=-1 (floor).
- **Output backpressure:** `out_ready` low for 5 cycles at row 3 → `out_data` and `out_last` stable, `rd_en`=0, row period 19 cycles, all values still correct.
- **Input bubbles and overlap:** feed inputs with random `in_valid` gaps, then hold `in_valid` high with a 12th word → 12th word not accepted until the cycle after the `out_last` handshake; that word becomes x[0] of the next vector.
- **Reset mid-row:** `rst` for one cycle during MAC of row 5 → `out_valid`=0 and `busy`=0 next cycle; a following fresh vector yields correct outputs.
